// File: rtl/mapa_write_arbiter_if.sv
// Purpose: groups the map-RAM write port, CPU/detector request channels and clear control.
// Latency: none (wiring only).
// Backpressure: requesters hold *_req until the matching one-cycle *_ack pulse.
//
// Ports (master = requester/testbench side, slave = arbiter side):
//   write_window  high = map RAM writes permitted (VGA blanking)
//   clear_req     one-cycle pulse starting a full-map clear
//   cpu_req/addr/dat, cpu_ack           CPU cell-write channel
//   det_req/addr/color/forma, det_ack   detector auto-mark channel
//   mapa_addr/mapa_dat/mapa_wr          map RAM write port
//   busy                                clear sweep in progress
interface mapa_write_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic              write_window;
  logic              clear_req;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dat;
  logic              cpu_ack;
  logic              det_req;
  logic [ADDR_W-1:0] det_addr;
  logic [1:0]        det_color;
  logic [1:0]        det_forma;
  logic              det_ack;
  logic [ADDR_W-1:0] mapa_addr;
  logic [DATA_W-1:0] mapa_dat;
  logic              mapa_wr;
  logic              busy;

  modport master (
    output write_window, clear_req,
    output cpu_req, cpu_addr, cpu_dat,
    output det_req, det_addr, det_color, det_forma,
    input  cpu_ack, det_ack, mapa_addr, mapa_dat, mapa_wr, busy
  );

  modport slave (
    input  write_window, clear_req,
    input  cpu_req, cpu_addr, cpu_dat,
    input  det_req, det_addr, det_color, det_forma,
    output cpu_ack, det_ack, mapa_addr, mapa_dat, mapa_wr, busy
  );
endinterface

// File: rtl/mapa_write_arbiter.sv
// Purpose: single writer for the 8x8 maze-map RAM, sharing it between CPU, detector and a clear sweep.
// Latency: write + ack appear one cycle after the grant decision; a clear takes MAP_CELLS window-high cycles.
// Backpressure: writes only while write_window is high; losers and requests during a clear stay pending.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     mapa_write_arbiter_if.slave (request channels in, map write port/acks/busy out)
module mapa_write_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 4,
  parameter int MAP_CELLS  = 64,
  parameter int CLEAR_CODE = 0
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  mapa_write_arbiter_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;          // 0: CPU wins next contest, 1: detector wins
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              det_ack_q, det_ack_d;
  logic              busy_q, busy_d;

  logic              cpu_ok, det_ok, pick_det;
  logic [DATA_W-1:0] det_code;

  // A source whose ack is high this cycle is still holding its old request;
  // masking it here is what makes one held request produce exactly one write.
  assign cpu_ok = bus.cpu_req & ~cpu_ack_q;
  assign det_ok = bus.det_req & ~det_ack_q;

  // Detector classification -> cell code: 1 empty, 3 unknown object, 4..6 by colour.
  always_comb begin
    det_code = DATA_W'(1);
    if (bus.det_color != 2'b00) begin
      if (bus.det_forma == 2'b00) det_code = DATA_W'(3);
      else                        det_code = DATA_W'(3 + int'(bus.det_color));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    dat_d     = dat_q;
    cpu_ack_d = 1'b0;
    det_ack_d = 1'b0;
    busy_d    = 1'b0;
    pick_det  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (bus.write_window && (cpu_ok || det_ok)) begin
          if (cpu_ok && det_ok) begin
            pick_det = ptr_q;
            ptr_d    = ~ptr_q;
          end else begin
            pick_det = det_ok;
          end
          wr_d = 1'b1;
          if (pick_det) begin
            addr_d    = bus.det_addr;
            dat_d     = det_code;
            det_ack_d = 1'b1;
          end else begin
            addr_d    = bus.cpu_addr;
            dat_d     = bus.cpu_dat;
            cpu_ack_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        // Busy follows the state of the decision cycle, so it stays high
        // through the last sweep write and falls together with it.
        busy_d = 1'b1;
        if (bus.write_window) begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          dat_d  = DATA_W'(CLEAR_CODE);
          cnt_d  = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(MAP_CELLS - 1)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      cpu_ack_q <= 1'b0;
      det_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      cpu_ack_q <= cpu_ack_d;
      det_ack_q <= det_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.mapa_wr   = wr_q;
  assign bus.mapa_addr = addr_q;
  assign bus.mapa_dat  = dat_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.det_ack   = det_ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mapa_write_arbiter.sv
// Purpose: self-checking bench for mapa_write_arbiter (vector table, corner sequences, random vs model).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: bench requesters hold requests until ack, then drop or change them.
module tb_mapa_write_arbiter;
  localparam int AW = 6;
  localparam int DW = 4;
  localparam int CELLS = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mapa_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mapa_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAP_CELLS(CELLS), .CLEAR_CODE(0)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int win, creq, caddr, cdat, dreq, daddr, dcol, dform;
    int e_wr, e_addr, e_dat, e_ca, e_da;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_window = 1'b1;
    bus.clear_req    = 1'b0;
    bus.cpu_req      = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_dat      = '0;
    bus.det_req      = 1'b0;
    bus.det_addr     = '0;
    bus.det_color    = '0;
    bus.det_forma    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Cell code the detector should produce, straight from the classification rules.
  function automatic int det_code(input int col, input int form);
    if (col == 0)  return 1;
    if (form == 0) return 3;
    return 3 + col;
  endfunction

  // Random-phase requester and reference-model state.
  logic c_ack_cycle, c_change, d_ack_cycle, d_change;
  logic m_clear, m_turn_det, m_cack, m_dack;
  int   m_left;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int writes, cyc, win_applied, exp_busy;
    logic got_ack, found;
    int e_wr, e_addr, e_dat, e_ca, e_da, e_busy;
    logic cw, dw, serve_det;

    tbl[0]  = '{1, 1, 9, 2,   0, 0, 0, 0,   1, 9, 2, 1, 0};
    tbl[1]  = '{1, 0, 0, 0,   1, 12, 2, 1,  1, 12, 5, 0, 1};
    tbl[2]  = '{1, 0, 0, 0,   1, 3, 0, 2,   1, 3, 1, 0, 1};
    tbl[3]  = '{1, 0, 0, 0,   1, 7, 3, 0,   1, 7, 3, 0, 1};
    tbl[4]  = '{1, 0, 0, 0,   1, 8, 1, 3,   1, 8, 4, 0, 1};
    tbl[5]  = '{1, 0, 0, 0,   1, 63, 3, 1,  1, 63, 6, 0, 1};
    tbl[6]  = '{0, 1, 5, 7,   0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 10, 15, 1, 11, 2, 0,  1, 10, 15, 1, 0};
    tbl[8]  = '{1, 1, 20, 14, 1, 21, 1, 1,  1, 21, 4, 0, 1};
    tbl[9]  = '{1, 1, 33, 8,  0, 0, 0, 0,   1, 33, 8, 1, 0};
    tbl[10] = '{1, 1, 1, 1,   1, 2, 0, 0,   1, 1, 1, 1, 0};
    tbl[11] = '{0, 1, 1, 1,   1, 2, 0, 0,   0, 0, 0, 0, 0};

    // Reset state and quiet idle with the window open.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle wr", 32'(bus.mapa_wr), 0);
      chk("idle addr", 32'(bus.mapa_addr), 0);
      chk("idle data", 32'(bus.mapa_dat), 0);
      chk("idle acks", 32'({bus.cpu_ack, bus.det_ack}), 0);
      chk("idle busy", 32'(bus.busy), 0);
    end

    // Vector table: each row is one decision cycle followed by a quiet gap cycle.
    for (int i = 0; i < 12; i++) begin
      bus.write_window = tbl[i].win[0];
      bus.cpu_req      = tbl[i].creq[0];
      bus.cpu_addr     = AW'(tbl[i].caddr);
      bus.cpu_dat      = DW'(tbl[i].cdat);
      bus.det_req      = tbl[i].dreq[0];
      bus.det_addr     = AW'(tbl[i].daddr);
      bus.det_color    = 2'(tbl[i].dcol);
      bus.det_forma    = 2'(tbl[i].dform);
      step();
      chk($sformatf("tbl%0d wr", i), 32'(bus.mapa_wr), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d cpu_ack", i), 32'(bus.cpu_ack), 32'(tbl[i].e_ca));
      chk($sformatf("tbl%0d det_ack", i), 32'(bus.det_ack), 32'(tbl[i].e_da));
      if (tbl[i].e_wr != 0) begin
        chk($sformatf("tbl%0d addr", i), 32'(bus.mapa_addr), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d data", i), 32'(bus.mapa_dat), 32'(tbl[i].e_dat));
      end
      idle_inputs();
      step();
    end

    // Held CPU request: pending while window low, then exactly one write.
    bus.cpu_req = 1'b1; bus.cpu_addr = 6'd9; bus.cpu_dat = 4'd2; bus.write_window = 1'b0;
    step();
    chk("held win0 wr", 32'(bus.mapa_wr), 0);
    bus.write_window = 1'b1;
    step();
    chk("held wr", 32'(bus.mapa_wr), 1);
    chk("held addr", 32'(bus.mapa_addr), 9);
    chk("held data", 32'(bus.mapa_dat), 2);
    chk("held ack", 32'(bus.cpu_ack), 1);
    step();
    chk("held no regrant", 32'(bus.mapa_wr), 0);
    bus.cpu_req = 1'b0;
    step();
    chk("held after drop", 32'(bus.mapa_wr), 0);

    // Both held: writes alternate CPU, DET, ...
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_addr = 6'd4; bus.cpu_dat = 4'd11;
    bus.det_req = 1'b1; bus.det_addr = 6'd12; bus.det_color = 2'b10; bus.det_forma = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt wr", 32'(bus.mapa_wr), 1);
      chk("alt cpu_ack", 32'(bus.cpu_ack), 32'(i % 2 == 0));
      chk("alt det_ack", 32'(bus.det_ack), 32'(i % 2 == 1));
      chk("alt addr", 32'(bus.mapa_addr), (i % 2 == 0) ? 32'd4 : 32'd12);
      chk("alt data", 32'(bus.mapa_dat), (i % 2 == 0) ? 32'd11 : 32'd5);
    end
    idle_inputs();
    step();

    // Clear sweep with window toggling every 8 cycles, CPU request raised mid-clear,
    // and a second clear pulse that must not restart the sweep.
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    chk("clear busy rise", 32'(bus.busy), 1);
    chk("clear no write", 32'(bus.mapa_wr), 0);
    writes = 0; cyc = 0; got_ack = 1'b0;
    while (!got_ack && cyc < 600) begin
      win_applied = ((cyc / 8) % 2 == 0) ? 1 : 0;
      bus.write_window = win_applied[0];
      if (cyc == 20) begin
        bus.cpu_req = 1'b1; bus.cpu_addr = 6'd50; bus.cpu_dat = 4'd9;
      end
      bus.clear_req = (cyc == 30);
      step();
      exp_busy = (writes < CELLS) ? 1 : 0;
      chk("clear busy", 32'(bus.busy), 32'(exp_busy));
      if (bus.cpu_ack) begin
        chk("clear cpu wr", 32'(bus.mapa_wr), 1);
        chk("clear cpu after sweep", 32'(writes), CELLS);
        chk("clear cpu addr", 32'(bus.mapa_addr), 50);
        chk("clear cpu data", 32'(bus.mapa_dat), 9);
        got_ack = 1'b1;
      end else if (bus.mapa_wr) begin
        chk("clear window", 32'(win_applied), 1);
        chk("clear addr", 32'(bus.mapa_addr), 32'(writes));
        chk("clear data", 32'(bus.mapa_dat), 0);
        writes++;
      end
      cyc++;
    end
    bus.clear_req = 1'b0;
    chk("clear write count", 32'(writes), CELLS);
    chk("clear cpu acked", 32'(got_ack), 1);
    bus.write_window = 1'b1;
    step();
    chk("clear cpu single write", 32'(bus.mapa_wr), 0);
    idle_inputs();
    step();

    // Reset asserted while the sweep is at address 20.
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (bus.mapa_wr && bus.mapa_addr == 6'd20) found = 1'b1;
    end
    chk("rst reach addr20", 32'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst wr", 32'(bus.mapa_wr), 0);
    chk("rst busy", 32'(bus.busy), 0);
    step();
    rst_n = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 6'd7; bus.cpu_dat = 4'd13;
    step();
    chk("rst idle wr", 32'(bus.mapa_wr), 1);
    chk("rst idle addr", 32'(bus.mapa_addr), 7);
    chk("rst idle data", 32'(bus.mapa_dat), 13);
    chk("rst idle busy", 32'(bus.busy), 0);
    step();
    idle_inputs();
    step();

    // Random traffic against the reference model.
    do_reset();
    c_ack_cycle = 0; c_change = 0; d_ack_cycle = 0; d_change = 0;
    m_clear = 0; m_turn_det = 0; m_cack = 0; m_dack = 0; m_left = 0;
    for (int n = 0; n < 800; n++) begin
      if (c_ack_cycle) begin
        c_ack_cycle = 0; c_change = 1;
      end else if (c_change || (!bus.cpu_req && $urandom_range(2) == 0)) begin
        c_change = 0;
        bus.cpu_req  = (bus.cpu_req && $urandom_range(1) == 0) ? 1'b0 : 1'b1;
        bus.cpu_addr = AW'($urandom);
        bus.cpu_dat  = DW'($urandom);
      end
      if (d_ack_cycle) begin
        d_ack_cycle = 0; d_change = 1;
      end else if (d_change || (!bus.det_req && $urandom_range(2) == 0)) begin
        d_change = 0;
        bus.det_req   = (bus.det_req && $urandom_range(1) == 0) ? 1'b0 : 1'b1;
        bus.det_addr  = AW'($urandom);
        bus.det_color = 2'($urandom);
        bus.det_forma = 2'($urandom);
      end
      bus.clear_req    = ($urandom_range(59) == 0);
      bus.write_window = ($urandom_range(3) != 0);

      e_wr = 0; e_addr = 0; e_dat = 0; e_ca = 0; e_da = 0; e_busy = 0;
      if (m_clear) begin
        e_busy = 1;
        if (bus.write_window) begin
          e_wr = 1; e_addr = CELLS - m_left; e_dat = 0;
          m_left--;
          if (m_left == 0) m_clear = 0;
        end
      end else if (bus.clear_req) begin
        m_clear = 1; m_left = CELLS; e_busy = 1;
      end else if (bus.write_window) begin
        cw = bus.cpu_req && !m_cack;
        dw = bus.det_req && !m_dack;
        serve_det = dw;
        if (cw && dw) begin
          serve_det  = m_turn_det;
          m_turn_det = !m_turn_det;
        end
        if (cw || dw) begin
          e_wr = 1;
          if (serve_det) begin
            e_da = 1; e_addr = int'(bus.det_addr);
            e_dat = det_code(int'(bus.det_color), int'(bus.det_forma));
          end else begin
            e_ca = 1; e_addr = int'(bus.cpu_addr); e_dat = int'(bus.cpu_dat);
          end
        end
      end
      m_cack = e_ca[0];
      m_dack = e_da[0];

      step();
      chk("rnd wr", 32'(bus.mapa_wr), 32'(e_wr));
      chk("rnd cpu_ack", 32'(bus.cpu_ack), 32'(e_ca));
      chk("rnd det_ack", 32'(bus.det_ack), 32'(e_da));
      chk("rnd busy", 32'(bus.busy), 32'(e_busy));
      if (e_wr != 0) begin
        chk("rnd addr", 32'(bus.mapa_addr), 32'(e_addr));
        chk("rnd data", 32'(bus.mapa_dat), 32'(e_dat));
      end
      if (bus.cpu_ack) c_ack_cycle = 1;
      if (bus.det_ack) d_ack_cycle = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
